// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader: transfer control, RAM read port and
// the outgoing valid/ready stream. The reader connects through the master
// modport; the RAM/producer/consumer environment uses the slave modport.
interface bram_stream_reader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 11
) ();
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  start, base_addr, length, ram_dout, m_ready,
    output busy, done, ram_en, ram_addr, m_data, m_valid
  );

  modport slave (
    output start, base_addr, length, ram_dout, m_ready,
    input  busy, done, ram_en, ram_addr, m_data, m_valid
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Drains a window of a simple-dual-port RAM through its read port and
// presents the words as a valid/ready stream. A 4-deep skid FIFO absorbs
// the RAM's one-cycle read latency; reads are only issued while the FIFO
// plus the read data still on its way can take another word.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 11
) (
  input  logic clk,
  input  logic rst_n,
  bram_stream_reader_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ram_en_q, ram_en_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  infl_q, infl_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [4];
  logic [DATA_WIDTH-1:0] fifo_mem_d [4];

  logic                  push;
  logic                  pop;
  logic                  m_valid;
  logic [3:0]            outstanding;
  logic                  credit_ok;

  // Read data lands on ram_dout exactly one cycle after each issued read.
  assign push    = infl_q;
  assign m_valid = (count_q != 3'd0);
  assign pop     = m_valid & bus.m_ready;

  // Words that will occupy the FIFO next cycle if nothing new is issued:
  // stored words, data arriving now, and the read issued this cycle.
  assign outstanding = 4'(count_q) + 4'(ram_en_q) + 4'(infl_q) - 4'(pop);
  assign credit_ok   = (outstanding < 4'd4);

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ram_en   = ram_en_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.m_valid  = m_valid;
  // Gate the head word so nothing stale shows while the stream is empty.
  assign bus.m_data   = m_valid ? fifo_mem_q[rd_ptr_q] : '0;

  // Transfer sequencing: accept start, issue reads under credit, wait for drain.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ram_en_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.length == '0) begin
            done_d = 1'b1;
          end else begin
            ram_en_d   = 1'b1;
            ram_addr_d = bus.base_addr;
            rem_d      = bus.length - LEN_WIDTH'(1);
            state_d    = (bus.length == LEN_WIDTH'(1)) ? S_DRAIN : S_READ;
          end
        end
      end
      S_READ: begin
        if (credit_ok) begin
          ram_en_d   = 1'b1;
          ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
          rem_d      = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!ram_en_q && !infl_q &&
            ((count_q == 3'd0) || ((count_q == 3'd1) && pop))) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Skid FIFO bookkeeping: unconditional push of returned data, pop on handshake.
  always_comb begin
    infl_d     = ram_en_q;
    wr_ptr_d   = wr_ptr_q + 2'(push);
    rd_ptr_d   = rd_ptr_q + 2'(pop);
    count_d    = count_q + 3'(push) - 3'(pop);
    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = bus.ram_dout;
  end

  // Control state; async reset discards any transfer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      infl_q     <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      infl_q     <= infl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are don't-care whenever the count says empty.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end
endmodule
